// File: rtl/ccip_mem_responder_if.sv
// rtl/ccip_mem_responder_if.sv - CCI-P style read/write request and response bundle
// addr_err exists only when CCIP_MEM_RSP_ADDR_CHECK_EN is defined.
interface ccip_mem_responder_if #(
  parameter int MEM_AW = 4
);
  logic              c0_req_valid;
  logic [41:0]       c0_req_addr;
  logic [15:0]       c0_req_mdata;
  logic              c1_req_valid;
  logic [41:0]       c1_req_addr;
  logic [15:0]       c1_req_mdata;
  logic [511:0]      c1_req_data;
  logic              c0_almfull;
  logic              c1_almfull;
  logic              c0_rsp_valid;
  logic [15:0]       c0_rsp_mdata;
  logic [511:0]      c0_rsp_data;
  logic              c1_rsp_valid;
  logic [15:0]       c1_rsp_mdata;
  logic              ld_en;
  logic [MEM_AW-1:0] ld_addr;
  logic [511:0]      ld_data;
`ifdef CCIP_MEM_RSP_ADDR_CHECK_EN
  logic              addr_err;

  modport master (
    output c0_req_valid, c0_req_addr, c0_req_mdata,
    output c1_req_valid, c1_req_addr, c1_req_mdata, c1_req_data,
    output ld_en, ld_addr, ld_data,
    input  c0_almfull, c1_almfull,
    input  c0_rsp_valid, c0_rsp_mdata, c0_rsp_data,
    input  c1_rsp_valid, c1_rsp_mdata, addr_err
  );

  modport slave (
    input  c0_req_valid, c0_req_addr, c0_req_mdata,
    input  c1_req_valid, c1_req_addr, c1_req_mdata, c1_req_data,
    input  ld_en, ld_addr, ld_data,
    output c0_almfull, c1_almfull,
    output c0_rsp_valid, c0_rsp_mdata, c0_rsp_data,
    output c1_rsp_valid, c1_rsp_mdata, addr_err
  );
`else
  modport master (
    output c0_req_valid, c0_req_addr, c0_req_mdata,
    output c1_req_valid, c1_req_addr, c1_req_mdata, c1_req_data,
    output ld_en, ld_addr, ld_data,
    input  c0_almfull, c1_almfull,
    input  c0_rsp_valid, c0_rsp_mdata, c0_rsp_data,
    input  c1_rsp_valid, c1_rsp_mdata
  );

  modport slave (
    input  c0_req_valid, c0_req_addr, c0_req_mdata,
    input  c1_req_valid, c1_req_addr, c1_req_mdata, c1_req_data,
    input  ld_en, ld_addr, ld_data,
    output c0_almfull, c1_almfull,
    output c0_rsp_valid, c0_rsp_mdata, c0_rsp_data,
    output c1_rsp_valid, c1_rsp_mdata
  );
`endif
endinterface

// File: rtl/ccip_mem_responder.sv
// rtl/ccip_mem_responder.sv - fixed-latency CCI-P memory model with read/write pipelines
// Optional out-of-range address checking via CCIP_MEM_RSP_ADDR_CHECK_EN.
module ccip_mem_responder #(
  parameter int MEM_AW     = 4,
  parameter int RD_LATENCY = 4,
  parameter int WR_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  ccip_mem_responder_if.slave  bus
);
  localparam int DEPTH = 1 << MEM_AW;

  logic [511:0]          mem_q [DEPTH];
  logic [MEM_AW-1:0]     rd_idx;
  logic [MEM_AW-1:0]     wr_idx;
  logic                  rd_oob;
  logic                  wr_oob;
  logic                  wr_commit;

  logic [RD_LATENCY-1:0] rd_vld_q, rd_vld_d;
  logic [15:0]           rd_tag_q  [RD_LATENCY];
  logic [15:0]           rd_tag_d  [RD_LATENCY];
  logic [511:0]          rd_data_q [RD_LATENCY];
  logic [511:0]          rd_data_d [RD_LATENCY];
  logic [WR_LATENCY-1:0] wr_vld_q, wr_vld_d;
  logic [15:0]           wr_tag_q  [WR_LATENCY];
  logic [15:0]           wr_tag_d  [WR_LATENCY];
  logic [4:0]            rd_cnt_q, rd_cnt_d;
  logic [4:0]            wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_idx = bus.c0_req_addr[MEM_AW-1:0];
    wr_idx = bus.c1_req_addr[MEM_AW-1:0];
`ifdef CCIP_MEM_RSP_ADDR_CHECK_EN
    rd_oob = |bus.c0_req_addr[41:MEM_AW];
    wr_oob = |bus.c1_req_addr[41:MEM_AW];
`else
    rd_oob = 1'b0;
    wr_oob = 1'b0;
`endif
    wr_commit = bus.c1_req_valid && !wr_oob;
  end

`ifndef CCIP_MEM_RSP_ADDR_CHECK_EN
  logic unused_upper_addr;
  assign unused_upper_addr = ^{bus.c0_req_addr[41:MEM_AW], bus.c1_req_addr[41:MEM_AW]};
`endif

  // Later assignment wins, so a same-line write overrides the preload.
  always_ff @(posedge clk) begin
    if (bus.ld_en) mem_q[bus.ld_addr] <= bus.ld_data;
    if (wr_commit) mem_q[wr_idx] <= bus.c1_req_data;
  end

  always_comb begin
    rd_vld_d  = '0;
    rd_tag_d  = '{default: '0};
    rd_data_d = '{default: '0};
    rd_vld_d[0]  = bus.c0_req_valid;
    rd_tag_d[0]  = bus.c0_req_valid ? bus.c0_req_mdata : 16'h0;
    // Memory is sampled before this edge's write lands, giving old data on a collision.
    rd_data_d[0] = (bus.c0_req_valid && !rd_oob) ? mem_q[rd_idx] : '0;
    for (int i = 1; i < RD_LATENCY; i++) begin
      rd_vld_d[i]  = rd_vld_q[i-1];
      rd_tag_d[i]  = rd_tag_q[i-1];
      rd_data_d[i] = rd_data_q[i-1];
    end

    wr_vld_d = '0;
    wr_tag_d = '{default: '0};
    wr_vld_d[0] = bus.c1_req_valid;
    wr_tag_d[0] = bus.c1_req_valid ? bus.c1_req_mdata : 16'h0;
    for (int i = 1; i < WR_LATENCY; i++) begin
      wr_vld_d[i] = wr_vld_q[i-1];
      wr_tag_d[i] = wr_tag_q[i-1];
    end
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (bus.c0_req_valid && !rd_vld_q[RD_LATENCY-1])      rd_cnt_d = rd_cnt_q + 5'd1;
    else if (!bus.c0_req_valid && rd_vld_q[RD_LATENCY-1]) rd_cnt_d = rd_cnt_q - 5'd1;

    wr_cnt_d = wr_cnt_q;
    if (bus.c1_req_valid && !wr_vld_q[WR_LATENCY-1])      wr_cnt_d = wr_cnt_q + 5'd1;
    else if (!bus.c1_req_valid && wr_vld_q[WR_LATENCY-1]) wr_cnt_d = wr_cnt_q - 5'd1;
  end

`ifdef CCIP_MEM_RSP_ADDR_CHECK_EN
  logic addr_err_q, addr_err_d;

  always_comb begin
    addr_err_d = addr_err_q | (bus.c0_req_valid & rd_oob) | (bus.c1_req_valid & wr_oob);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) addr_err_q <= 1'b0;
    else          addr_err_q <= addr_err_d;
  end

  assign bus.addr_err = addr_err_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_q  <= '0;
      rd_tag_q  <= '{default: '0};
      rd_data_q <= '{default: '0};
      wr_vld_q  <= '0;
      wr_tag_q  <= '{default: '0};
      rd_cnt_q  <= 5'd0;
      wr_cnt_q  <= 5'd0;
    end else begin
      rd_vld_q  <= rd_vld_d;
      rd_tag_q  <= rd_tag_d;
      rd_data_q <= rd_data_d;
      wr_vld_q  <= wr_vld_d;
      wr_tag_q  <= wr_tag_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  assign bus.c0_rsp_valid = rd_vld_q[RD_LATENCY-1];
  assign bus.c0_rsp_mdata = rd_tag_q[RD_LATENCY-1];
  assign bus.c0_rsp_data  = rd_data_q[RD_LATENCY-1];
  assign bus.c1_rsp_valid = wr_vld_q[WR_LATENCY-1];
  assign bus.c1_rsp_mdata = wr_tag_q[WR_LATENCY-1];

  // A latency of 1 can never back up, so its almfull is tied off.
  if (RD_LATENCY > 1) begin : g_rd_af
    assign bus.c0_almfull = (rd_cnt_q >= 5'(RD_LATENCY - 1));
  end else begin : g_rd_no_af
    assign bus.c0_almfull = 1'b0;
  end

  if (WR_LATENCY > 1) begin : g_wr_af
    assign bus.c1_almfull = (wr_cnt_q >= 5'(WR_LATENCY - 1));
  end else begin : g_wr_no_af
    assign bus.c1_almfull = 1'b0;
  end
endmodule

// File: tb/tb_ccip_mem_responder.sv
// tb/tb_ccip_mem_responder.sv - scoreboard bench for ccip_mem_responder
// Reference memory plus expected-response queues; monitor checks every falling edge.
module tb_ccip_mem_responder;
  localparam int MEM_AW = 4;
  localparam int RD_LAT = 4;
  localparam int WR_LAT = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ccip_mem_responder_if #(.MEM_AW(MEM_AW)) bus ();

  ccip_mem_responder #(
    .MEM_AW(MEM_AW), .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  typedef struct {
    int           due;
    logic [15:0]  tag;
    logic [511:0] data;
  } exp_t;

  exp_t         rd_q[$];
  exp_t         wr_q[$];
  logic [511:0] ref_mem [1 << MEM_AW];
  int           err_cyc = -1;
  int           cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name, input int value);
    n_tests++;
    n_fail++;
    $display("FAIL %s: observed %0d, none expected", name, value);
  endtask

  function automatic bit is_oob(input logic [41:0] a);
`ifdef CCIP_MEM_RSP_ADDR_CHECK_EN
    return a[41:MEM_AW] != '0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [41:0] rand_addr();
    if ($urandom_range(0, 99) < 15) return {$urandom, $urandom};
    return 42'($urandom_range(0, (1 << MEM_AW) - 1));
  endfunction

  // Called on a falling edge; the request is accepted at the next rising edge.
  task automatic issue(input bit rd, input logic [41:0] ra, input logic [15:0] rt,
                       input bit wr, input logic [41:0] wa, input logic [15:0] wt,
                       input logic [511:0] wd,
                       input bit ld, input logic [MEM_AW-1:0] la, input logic [511:0] lw);
    exp_t e;
    bus.c0_req_valid = rd;  bus.c0_req_addr = ra;  bus.c0_req_mdata = rt;
    bus.c1_req_valid = wr;  bus.c1_req_addr = wa;  bus.c1_req_mdata = wt;
    bus.c1_req_data  = wd;
    bus.ld_en = ld;  bus.ld_addr = la;  bus.ld_data = lw;
    if (rd) begin
      e.due  = cyc + RD_LAT;
      e.tag  = rt;
      e.data = is_oob(ra) ? '0 : ref_mem[ra[MEM_AW-1:0]];
      rd_q.push_back(e);
      if (is_oob(ra) && err_cyc < 0) err_cyc = cyc + 1;
    end
    if (wr) begin
      e.due  = cyc + WR_LAT;
      e.tag  = wt;
      e.data = '0;
      wr_q.push_back(e);
      if (is_oob(wa) && err_cyc < 0) err_cyc = cyc + 1;
    end
    if (ld) ref_mem[la] = lw;
    if (wr && !is_oob(wa)) ref_mem[wa[MEM_AW-1:0]] = wd;
    @(negedge clk);
  endtask

  task automatic idle();
    bus.c0_req_valid = 1'b0;
    bus.c1_req_valid = 1'b0;
    bus.ld_en        = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd1(input logic [41:0] a, input logic [15:0] t);
    issue(1'b1, a, t, 1'b0, '0, '0, '0, 1'b0, '0, '0);
  endtask

  int   mon_rd_out;
  int   mon_wr_out;
  exp_t mon_e;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_c0_rsp_valid", bus.c0_rsp_valid, 0);
      chk("rst_c1_rsp_valid", bus.c1_rsp_valid, 0);
      chk("rst_c0_rsp_data", bus.c0_rsp_data, 0);
      chk("rst_c0_rsp_mdata", bus.c0_rsp_mdata, 0);
      chk("rst_c1_rsp_mdata", bus.c1_rsp_mdata, 0);
      chk("rst_c0_almfull", bus.c0_almfull, 0);
      chk("rst_c1_almfull", bus.c1_almfull, 0);
`ifdef CCIP_MEM_RSP_ADDR_CHECK_EN
      chk("rst_addr_err", bus.addr_err, 0);
`endif
    end else begin
      mon_rd_out = 0;
      mon_wr_out = 0;
      foreach (rd_q[i]) if (rd_q[i].due - RD_LAT + 1 <= cyc) mon_rd_out++;
      foreach (wr_q[i]) if (wr_q[i].due - WR_LAT + 1 <= cyc) mon_wr_out++;
      chk("c0_almfull", bus.c0_almfull, (RD_LAT > 1) && (mon_rd_out >= RD_LAT - 1));
      chk("c1_almfull", bus.c1_almfull, (WR_LAT > 1) && (mon_wr_out >= WR_LAT - 1));
`ifdef CCIP_MEM_RSP_ADDR_CHECK_EN
      chk("addr_err", bus.addr_err, (err_cyc >= 0) && (cyc >= err_cyc));
`endif
      if (bus.c0_rsp_valid) begin
        if (rd_q.size() == 0) fail_msg("c0_rsp_unexpected", cyc);
        else begin
          mon_e = rd_q.pop_front();
          chk("c0_rsp_cycle", cyc, mon_e.due);
          chk("c0_rsp_mdata", bus.c0_rsp_mdata, mon_e.tag);
          chk("c0_rsp_data", bus.c0_rsp_data, mon_e.data);
        end
      end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        mon_e = rd_q.pop_front();
        chk("c0_rsp_missing", 0, 1);
      end
      if (bus.c1_rsp_valid) begin
        if (wr_q.size() == 0) fail_msg("c1_rsp_unexpected", cyc);
        else begin
          mon_e = wr_q.pop_front();
          chk("c1_rsp_cycle", cyc, mon_e.due);
          chk("c1_rsp_mdata", bus.c1_rsp_mdata, mon_e.tag);
        end
      end else if (wr_q.size() > 0 && wr_q[0].due <= cyc) begin
        mon_e = wr_q.pop_front();
        chk("c1_rsp_missing", 0, 1);
      end
    end
  end

  logic [511:0] lw;
  bit           seen_af;
  int           n_rd;
  int           guard;
  bit           r_rd, r_wr, r_ld;

  initial begin
    bus.c0_req_valid = 1'b0;  bus.c0_req_addr = '0;  bus.c0_req_mdata = '0;
    bus.c1_req_valid = 1'b0;  bus.c1_req_addr = '0;  bus.c1_req_mdata = '0;
    bus.c1_req_data  = '0;
    bus.ld_en = 1'b0;  bus.ld_addr = '0;  bus.ld_data = '0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < (1 << MEM_AW); i++)
      issue(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b1, MEM_AW'(i), rand512());

    // Preload {b=7,a=6} into line 0 and read it back.
    lw = rand512();
    lw[63:0] = {32'd7, 32'd6};
    issue(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b1, '0, lw);
    rd1(42'd0, 16'h0011);
    repeat (RD_LAT - 1) idle();
    chk("req027_valid", bus.c0_rsp_valid, 1);
    chk("req027_a", bus.c0_rsp_data[31:0], 6);
    chk("req027_b", bus.c0_rsp_data[63:32], 7);
    chk("req027_mdata", bus.c0_rsp_mdata, 16'h0011);

    issue(1'b0, '0, '0, 1'b1, 42'd3, 16'h0005, 512'd42, 1'b0, '0, '0);
    repeat (WR_LAT - 1) idle();
    chk("req028_ack", bus.c1_rsp_valid, 1);
    chk("req028_mdata", bus.c1_rsp_mdata, 16'h0005);
    rd1(42'd3, 16'h0033);
    repeat (RD_LAT - 1) idle();
    chk("req028_rdata", bus.c0_rsp_data, 512'd42);

    issue(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b1, 4'd1, 512'd5);
    issue(1'b1, 42'd1, 16'h0101, 1'b1, 42'd1, 16'h0202, 512'd99, 1'b0, '0, '0);
    repeat (RD_LAT - 1) idle();
    chk("req030_old", bus.c0_rsp_data, 512'd5);
    rd1(42'd1, 16'h0102);
    repeat (RD_LAT - 1) idle();
    chk("req030_new", bus.c0_rsp_data, 512'd99);

    issue(1'b0, '0, '0, 1'b1, 42'd2, 16'h0303, 512'd77, 1'b1, 4'd2, 512'd88);
    rd1(42'd2, 16'h0304);
    repeat (RD_LAT - 1) idle();
    chk("req018_write_wins", bus.c0_rsp_data, 512'd77);

    seen_af = 1'b0;
    n_rd = 0;
    guard = 0;
    while (n_rd < 8 && guard < 100) begin
      guard++;
      if (bus.c0_almfull) begin
        seen_af = 1'b1;
        idle();
      end else begin
        rd1(42'(n_rd), 16'h0a00 + 16'(n_rd));
        n_rd++;
      end
    end
    if (n_rd < 8) fail_msg("req029_timeout", n_rd);
    chk("req029_almfull_seen", seen_af, 1);
    repeat (RD_LAT + 1) idle();

    rd1(42'h10, 16'h0c0c);
    repeat (RD_LAT - 1) idle();
`ifdef CCIP_MEM_RSP_ADDR_CHECK_EN
    chk("req032_zero", bus.c0_rsp_data, 0);
    chk("req032_err", bus.addr_err, 1);
`else
    chk("req032_wrap", bus.c0_rsp_data[63:0], {32'd7, 32'd6});
`endif
    repeat (3) idle();

    // Reset with a read and a write still in flight.
    rd1(42'd5, 16'hbeef);
    issue(1'b0, '0, '0, 1'b1, 42'd6, 16'hcafe, 512'd1234, 1'b0, '0, '0);
    idle();
    #2 reset_n = 1'b0;
    rd_q.delete();
    wr_q.delete();
    err_cyc = -1;
    #1;
    chk("req031_rd_cnt_async", dut.rd_cnt_q, 0);
    chk("req031_wr_cnt_async", dut.wr_cnt_q, 0);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("req031_rd_cnt", dut.rd_cnt_q, 0);
    chk("req031_wr_cnt", dut.wr_cnt_q, 0);
    rd1(42'd6, 16'h0606);
    rd1(42'd5, 16'h0505);
    repeat (RD_LAT + 2) idle();

    for (int k = 0; k < 400; k++) begin
      r_rd = ($urandom_range(0, 99) < 60) && !bus.c0_almfull;
      r_wr = ($urandom_range(0, 99) < 50) && !bus.c1_almfull;
      r_ld = ($urandom_range(0, 99) < 20);
      issue(r_rd, rand_addr(), 16'($urandom), r_wr, rand_addr(), 16'($urandom), rand512(),
            r_ld, MEM_AW'($urandom_range(0, (1 << MEM_AW) - 1)), rand512());
    end
    repeat (RD_LAT + WR_LAT + 4) idle();
    chk("rd_queue_drained", rd_q.size(), 0);
    chk("wr_queue_drained", wr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: time %0t exceeded budget", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end
endmodule
